// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: EX-stage handshake and result bus between the pipeline and the divider.
interface div_seq_ctrl_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    modport master (output start, op, dividend, divisor, flush, input stall, busy, done, result);
    modport slave  (input start, op, dividend, divisor, flush, output stall, busy, done, result);
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative radix-2 divider sequencer/datapath for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_FAST_SPECIAL_EN retires divide-by-zero and signed overflow straight from IDLE.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    div_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t           state, next;
    logic [WIDTH-1:0] rem, quo, dvs, res;
    logic [CNT_W-1:0] cnt;
    logic             sel_rem, q_neg, r_neg, dz;
    logic             accept, sgn, a_neg, b_neg, fast;
    logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
    logic [WIDTH:0]   diff;
    assign accept  = state == IDLE && bus.start && !bus.flush;
    assign sgn     = !bus.op[0];
    assign a_neg   = sgn && bus.dividend[WIDTH-1];
    assign b_neg   = sgn && bus.divisor[WIDTH-1];
    assign a_abs   = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs   = b_neg ? -bus.divisor : bus.divisor;
    // diff[WIDTH] set means the shifted remainder is below the divisor
    assign diff    = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    // signed divide-by-zero would otherwise get its all-ones quotient negated
    assign quo_fix = dz ? '1 : q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem : rem;
`ifdef DIV_FAST_SPECIAL_EN
    logic             spec_dz, spec_ovf;
    logic [WIDTH-1:0] spec_res;
    assign spec_dz  = bus.divisor == '0;
    assign spec_ovf = sgn && bus.dividend == {1'b1, {(WIDTH-1){1'b0}}} && bus.divisor == '1;
    assign fast     = spec_dz || spec_ovf;
    assign spec_res = spec_dz ? (bus.op[1] ? bus.dividend : '1) : (bus.op[1] ? '0 : bus.dividend);
`else
    assign fast = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? (fast ? DONE : BUSY) : IDLE;
            BUSY:    next = bus.flush ? IDLE : (cnt == CNT_W'(1) ? FIX : BUSY);
            FIX:     next = bus.flush ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            res     <= '0;
            cnt     <= '0;
            sel_rem <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
        end else if (accept) begin
            sel_rem <= bus.op[1];
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            dz      <= bus.divisor == '0;
            rem     <= '0;
            quo     <= a_abs;
            dvs     <= b_abs;
            cnt     <= CNT_W'(WIDTH);
`ifdef DIV_FAST_SPECIAL_EN
            if (fast) res <= spec_res;
`endif
        end else if (state == BUSY) begin
            rem <= diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], !diff[WIDTH]};
            cnt <= cnt - CNT_W'(1);
        end else if (state == FIX && !bus.flush) begin
            res <= sel_rem ? rem_fix : quo_fix;
        end
    end
    assign bus.stall  = accept || state == BUSY || state == FIX;
    assign bus.busy   = state == BUSY || state == FIX;
    assign bus.done   = state == DONE;
    assign bus.result = res;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed scoreboard bench for div_seq_ctrl (honours DIV_FAST_SPECIAL_EN).
module tb_div_seq_ctrl;
    typedef struct {logic [31:0] res; int lat;} exp_t;
    logic clk = 0, rst_n = 0;
    int cyc = 0, t0 = 0, tests = 0, fails = 0;
    logic [31:0] last_res = 0;
    exp_t sb[$];
    div_seq_ctrl_if #(32) bus();
    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0]) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
            return op[1] ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
        end
        return op[1] ? a % b : a / b;
    endfunction
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        if (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
`endif
        return 34;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        bus.start = 1; bus.op = op; bus.dividend = a; bus.divisor = b;
        e.res = model(op, a, b);
        e.lat = exp_lat(op, a, b);
        sb.push_back(e);
        t0 = cyc;
        #1 chk("stall_issue", bus.stall, 1);
        @(posedge clk);
        #1 bus.start = 0;
    endtask
    task automatic wait_done(input string tag);
        exp_t e;
        bit got = 0, stall_ok = 1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.done) begin got = 1; break; end
            if (!bus.stall) stall_ok = 0;
        end
        e = sb.pop_front();
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            chk({tag, "_result"}, bus.result, e.res);
            chk({tag, "_latency"}, cyc - t0, e.lat);
            chk({tag, "_stall_at_done"}, bus.stall, 0);
            chk({tag, "_stall_held"}, stall_ok, 1);
            last_res = e.res;
        end
    endtask
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(tag);
    endtask
    initial begin
        bus.start = 0; bus.flush = 0; bus.op = 0; bus.dividend = 0; bus.divisor = 0;
        #23;
        chk("rst_stall", bus.stall, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        @(negedge clk) rst_n = 1;
        run("divu_100_7", 2'b01, 100, 7);
        run("remu_100_7", 2'b11, 100, 7);
        run("div_m20_3", 2'b00, 32'hFFFFFFEC, 3);
        run("rem_m20_3", 2'b10, 32'hFFFFFFEC, 3);
        run("rem_20_m3", 2'b10, 20, 32'hFFFFFFFD);
        run("divu_5_0", 2'b01, 5, 0);
        run("rem_5_0", 2'b10, 5, 0);
        run("div_m5_0", 2'b00, 32'hFFFFFFFB, 0);
        run("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF);
        run("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF);
        run("div_m7_m2", 2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE);
        // start and flush together in IDLE: nothing begins
        @(negedge clk);
        bus.start = 1; bus.flush = 1; bus.op = 2'b01; bus.dividend = 9; bus.divisor = 2;
        #1 chk("startflush_stall", bus.stall, 0);
        @(posedge clk);
        #1 bus.start = 0; bus.flush = 0;
        chk("startflush_busy", bus.busy, 0);
        // flush in cycle 10 of a DIVU
        issue(2'b01, 50, 3);
        while (cyc != t0 + 10) begin
            @(negedge clk);
            chk("flush_no_done_early", bus.done, 0);
        end
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        chk("flush_stall_c11", bus.stall, 0);
        chk("flush_busy_c11", bus.busy, 0);
        chk("flush_done_c11", bus.done, 0);
        chk("flush_result_kept", bus.result, last_res);
        void'(sb.pop_front());
        run("after_flush", 2'b01, 1234567, 89);
        chk("after_flush_abs_cycle", cyc - t0 + 12, 46);
        // reset in cycle 20 of an operation
        issue(2'b01, 1000, 3);
        while (cyc != t0 + 20) @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_stall", bus.stall, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_result", bus.result, 0);
        void'(sb.pop_front());
        @(negedge clk) rst_n = 1;
        run("divu_max_1", 2'b01, 32'hFFFFFFFF, 1);
        // start while BUSY is ignored, then back-to-back start after DONE
        issue(2'b01, 1000, 10);
        while (cyc != t0 + 5) @(negedge clk);
        bus.start = 1; bus.op = 2'b11; bus.dividend = 77; bus.divisor = 5;
        @(posedge clk);
        #1 bus.start = 0;
        wait_done("ignore_restart");
        run("back_to_back", 2'b11, 77, 5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
